// File: rtl/div_seq_n_pkg.sv
// Shared definitions for the sequential divider: default operand width and
// the controller state encoding, used by the RTL and its bench.
package div_seq_n_pkg;

  localparam int DIV_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_seq_n_div_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference only when it
// does not borrow. The produced quotient bit enters at the LSB of the
// shifting dividend/quotient register.
module div_step #(
  parameter int bits = 8
) (
  input  logic [bits-1:0] rem_in,
  input  logic [bits-1:0] quo_in,
  input  logic [bits-1:0] dvsr,
  output logic [bits-1:0] rem_out,
  output logic [bits-1:0] quo_out
);

  logic [bits:0]   rem_shift;
  logic [bits-1:0] trial;
  logic            q_bit;

  // shift, trial subtract, select; the partial remainder is always below the
  // divisor, so a non-negative difference always fits in bits bits
  always_comb begin
    rem_shift = {rem_in, quo_in[bits-1]};
    trial     = rem_shift[bits-1:0] - dvsr;
    q_bit     = (rem_shift >= {1'b0, dvsr});
    rem_out   = q_bit ? trial : rem_shift[bits-1:0];
    quo_out   = {quo_in[bits-2:0], q_bit};
  end

endmodule

// File: rtl/div_seq_n.sv
// Sequential restoring divider, unsigned or two's-complement signed.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; operands and mode latched on the start edge
// CALC  | one shift-subtract step per cycle, bits cycles, MSB first
// FIX   | sign correction / divide-by-zero handling, results loaded
// DONE  | ready pulses for this single cycle, then back to IDLE
//
// Signed operands are reduced to magnitudes before CALC, so the datapath
// is purely unsigned. The most-negative value keeps its own bit pattern as
// a magnitude, which makes most-negative / -1 wrap back to most-negative
// without special handling of the quotient; only the ovf flag is extra.
module div_seq_n
  import div_seq_n_pkg::*;
#(
  parameter int bits = DIV_BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sign,
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  output logic [bits-1:0] div,
  output logic [bits-1:0] mod,
  output logic            ready,
  output logic            busy,
  output logic            div_err,
  output logic            ovf
);

  localparam logic [bits-1:0] ITER_LOAD = bits'(bits);
  localparam logic [bits-1:0] CNT_LAST  = {{(bits-1){1'b0}}, 1'b1};
  localparam logic [bits-1:0] MOST_NEG  = {1'b1, {(bits-1){1'b0}}};
  localparam logic [bits-1:0] ALL_ONES  = {bits{1'b1}};
  localparam logic [bits-1:0] ZERO      = {bits{1'b0}};

  div_state_t      state, state_next;

  logic [bits-1:0] quo_r;
  logic [bits-1:0] rem_r;
  logic [bits-1:0] dvsr_r;
  logic [bits-1:0] a_l;
  logic [bits-1:0] cnt;
  logic            q_neg;
  logic            r_neg;
  logic            div_zero;
  logic            ovf_case;

  logic [bits-1:0] a_mag;
  logic [bits-1:0] b_mag;
  logic [bits-1:0] rem_step;
  logic [bits-1:0] quo_step;
  logic [bits-1:0] quo_fix;
  logic [bits-1:0] rem_fix;
  logic            take;

  assign take = (state == IDLE) && start;

  // operand magnitudes as seen at the start edge
  always_comb begin
    a_mag = (sign && a[bits-1]) ? (~a + 1'b1) : a;
    b_mag = (sign && b[bits-1]) ? (~b + 1'b1) : b;
  end

  // signed results: quotient truncates toward zero, remainder follows the dividend
  always_comb begin
    quo_fix = q_neg ? (~quo_r + 1'b1) : quo_r;
    rem_fix = r_neg ? (~rem_r + 1'b1) : rem_r;
  end

  div_step #(
    .bits (bits)
  ) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dvsr    (dvsr_r),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; CALC ends on the terminal count of the iteration timer
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (b == ZERO) ? FIX : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // operand latch, iteration datapath and down-counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_r    <= ZERO;
      rem_r    <= ZERO;
      dvsr_r   <= ZERO;
      a_l      <= ZERO;
      cnt      <= ZERO;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      ovf_case <= 1'b0;
    end else if (take) begin
      quo_r    <= a_mag;
      rem_r    <= ZERO;
      dvsr_r   <= b_mag;
      a_l      <= a;
      cnt      <= ITER_LOAD;
      q_neg    <= sign && (a[bits-1] ^ b[bits-1]);
      r_neg    <= sign && a[bits-1];
      div_zero <= (b == ZERO);
      ovf_case <= sign && (a == MOST_NEG) && (b == ALL_ONES);
    end else if (state == CALC) begin
      quo_r <= quo_step;
      rem_r <= rem_step;
      cnt   <= cnt - 1'b1;
    end
  end

  // result registers, loaded together on the FIX edge and held until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div     <= ZERO;
      mod     <= ZERO;
      div_err <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == FIX) begin
      if (div_zero) begin
        div     <= ALL_ONES;
        mod     <= a_l;
        div_err <= 1'b1;
        ovf     <= 1'b0;
      end else begin
        div     <= quo_fix;
        mod     <= rem_fix;
        div_err <= 1'b0;
        ovf     <= ovf_case;
      end
    end
  end

  // registered status: ready coincides with DONE, busy covers CALC..DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ready <= (state == FIX);
      busy  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_div_seq_n.sv
// Bench for div_seq_n: an 8-bit and a 16-bit instance. Expected results come
// from a reference model using integer division and are queued when a start
// is driven; a monitor per instance pops and compares on each ready pulse.
// Latency is the number of rising edges from the start-sample edge up to
// and including the first edge that sees ready high.
module tb_div_seq_n;
  import div_seq_n_pkg::*;

  localparam int W8  = DIV_BITS_DEFAULT;
  localparam int W16 = 16;

  typedef struct {
    logic [15:0] div;
    logic [15:0] mod;
    logic        err;
    logic        ovf;
    int          lat;
    int          t0;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            start8, sign8;
  logic [W8-1:0]   a8, b8, div8, mod8;
  logic            ready8, busy8, err8, ovf8;
  logic            start16, sign16;
  logic [W16-1:0]  a16, b16, div16, mod16;
  logic            ready16, busy16, err16, ovf16;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done8 = 0;
  int   done16 = 0;
  int   busy_run8 = 0;
  bit   after8 = 1'b0;
  exp_t last8;
  exp_t q8[$];
  exp_t q16[$];

  div_seq_n #(.bits(W8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sign(sign8), .a(a8), .b(b8),
    .div(div8), .mod(mod8), .ready(ready8), .busy(busy8), .div_err(err8), .ovf(ovf8)
  );

  div_seq_n #(.bits(W16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sign(sign16), .a(a16), .b(b16),
    .div(div16), .mod(mod16), .ready(ready16), .busy(busy16), .div_err(err16), .ovf(ovf16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input bit sgn, input logic [15:0] a,
                                 input logic [15:0] b, input int t0, input string tag);
    exp_t e;
    longint          sa, sb, q, r;
    longint unsigned mask;
    mask  = (longint'(1) << w) - 1;
    e.tag = tag;
    e.t0  = t0;
    e.err = 1'b0;
    e.ovf = 1'b0;
    if (b == 16'd0) begin
      e.div = mask[15:0];
      e.mod = a;
      e.err = 1'b1;
      e.lat = 2;
      return e;
    end
    e.lat = w + 2;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    q = sa / sb;
    r = sa % sb;
    if (sgn && sa == -(longint'(1) << (w - 1)) && sb == -1) e.ovf = 1'b1;
    e.div = 16'(q & mask);
    e.mod = 16'(r & mask);
    return e;
  endfunction

  // 8-bit monitor: scoreboard compare on ready, idle/hold check one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (after8) begin
        check_val({last8.tag, "_idle_busy"}, 32'(busy8), 32'd0);
        check_val({last8.tag, "_hold_div"}, 32'(div8), 32'(last8.div[7:0]));
        after8 = 1'b0;
      end
      if (busy8) busy_run8++;
      if (ready8) begin
        if (q8.size() == 0) begin
          check_val("spurious_ready8", 32'(ready8), 32'd0);
        end else begin
          e = q8.pop_front();
          check_val({e.tag, "_div"}, 32'(div8), 32'(e.div[7:0]));
          check_val({e.tag, "_mod"}, 32'(mod8), 32'(e.mod[7:0]));
          check_val({e.tag, "_err"}, 32'(err8), 32'(e.err));
          check_val({e.tag, "_ovf"}, 32'(ovf8), 32'(e.ovf));
          check_val({e.tag, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
          check_val({e.tag, "_busy"}, 32'(busy_run8), 32'(e.lat));
          last8  = e;
          after8 = 1'b1;
        end
        done8++;
      end
    end
  end

  // 16-bit monitor
  always @(negedge clk) begin
    exp_t e;
    if (reset && ready16) begin
      if (q16.size() == 0) begin
        check_val("spurious_ready16", 32'(ready16), 32'd0);
      end else begin
        e = q16.pop_front();
        check_val({e.tag, "_div"}, 32'(div16), 32'(e.div));
        check_val({e.tag, "_mod"}, 32'(mod16), 32'(e.mod));
        check_val({e.tag, "_err"}, 32'(err16), 32'(e.err));
        check_val({e.tag, "_ovf"}, 32'(ovf16), 32'(e.ovf));
        check_val({e.tag, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
      end
      done16++;
    end
  end

  task automatic wait_done8(input int n0, input string tag);
    int k = 0;
    while (done8 == n0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (done8 == n0) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
      q8.delete();
    end
  endtask

  task automatic wait_done16(input int n0, input string tag);
    int k = 0;
    while (done16 == n0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (done16 == n0) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
      q16.delete();
    end
  endtask

  // drive one start, queue its expectation, scramble the operand pins after
  // the sample edge; optionally pulse start mid-CALC with other operands
  task automatic op8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                     input string tag, input bit disturb);
    int n0;
    @(negedge clk);
    start8 = 1'b1; sign8 = sgn; a8 = a; b8 = b;
    busy_run8 = 0;
    q8.push_back(model(W8, sgn, {8'h00, a}, {8'h00, b}, cyc, tag));
    n0 = done8;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sign8 = 1'($urandom);
    if (disturb) begin
      repeat (3) @(negedge clk);
      start8 = 1'b1; sign8 = 1'b0; a8 = 8'd9; b8 = 8'd3;
      @(negedge clk);
      start8 = 1'b0;
    end
    wait_done8(n0, tag);
  endtask

  task automatic op16(input bit sgn, input logic [15:0] a, input logic [15:0] b, input string tag);
    int n0;
    @(negedge clk);
    start16 = 1'b1; sign16 = sgn; a16 = a; b16 = b;
    q16.push_back(model(W16, sgn, a, b, cyc, tag));
    n0 = done16;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    wait_done16(n0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start8 = 1'b0; sign8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sign16 = 1'b0; a16 = '0; b16 = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_div", 32'(div8), 32'd0);
    check_val("rst_mod", 32'(mod8), 32'd0);
    check_val("rst_ready", 32'(ready8), 32'd0);
    check_val("rst_busy", 32'(busy8), 32'd0);
    check_val("rst_err", 32'(err8), 32'd0);
    check_val("rst_ovf", 32'(ovf8), 32'd0);
    reset = 1'b1;

    op8(1'b0, 8'd100, 8'd7,   "u100_7", 1'b0);
    op8(1'b1, 8'hF9,  8'h02,  "s_m7_2", 1'b0);
    op8(1'b0, 8'd200, 8'd0,   "u_div0", 1'b0);
    op8(1'b1, 8'h80,  8'hFF,  "s_ovf", 1'b0);
    op8(1'b1, 8'hC8,  8'h00,  "s_div0", 1'b0);
    op8(1'b0, 8'hFF,  8'h10,  "u255_16", 1'b0);
    op8(1'b1, 8'h7F,  8'hFD,  "s127_m3", 1'b0);
    op8(1'b1, 8'h80,  8'h07,  "s_m128_7", 1'b0);
    op8(1'b0, 8'h80,  8'hFF,  "u128_255", 1'b0);
    op8(1'b0, 8'd5,   8'd9,   "u5_9", 1'b0);
    for (int i = 0; i < 12; i++) begin
      op8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i), 1'b0);
    end

    op8(1'b0, 8'd77, 8'd5, "midstart", 1'b1);

    // abort mid-CALC: no expectation is queued, so any ready is spurious
    @(negedge clk);
    start8 = 1'b1; sign8 = 1'b0; a8 = 8'd50; b8 = 8'd3;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("abort_div", 32'(div8), 32'd0);
    check_val("abort_mod", 32'(mod8), 32'd0);
    check_val("abort_ready", 32'(ready8), 32'd0);
    check_val("abort_busy", 32'(busy8), 32'd0);
    check_val("abort_err", 32'(err8), 32'd0);
    check_val("abort_ovf", 32'(ovf8), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check_val("abort_idle_busy", 32'(busy8), 32'd0);
    op8(1'b0, 8'd100, 8'd7, "after_abort", 1'b0);

    op16(1'b0, 16'hFFFF, 16'h0001, "w16_max_1");
    op16(1'b1, 16'h8000, 16'hFFFF, "w16_ovf");
    op16(1'b1, 16'hD8F1, 16'h0064, "w16_neg");
    op16(1'b0, 16'h1234, 16'h0000, "w16_div0");

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_n.md
DIV_SEQ_N -- requirements
Module: div_seq_N

Interface
REQ-001 SHALL have parameter bits, default 8, meaning operand/result width (≥2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port sign, input, 1, mode select: 0 unsigned, 1 two's-complement signed; sampled with start.
REQ-006 SHALL have ports a and b, input, bits each: dividend and divisor; sampled with start.
REQ-007 SHALL have port div, output, bits, quotient.
REQ-008 SHALL have port mod, output, bits, remainder.
REQ-009 SHALL have port ready, output, 1, one-cycle result-valid pulse.
REQ-010 SHALL have port busy, output, 1, high while a division is in progress.
REQ-011 SHALL have port div_err, output, 1, divide-by-zero flag for the current result.
REQ-012 SHALL have port ovf, output, 1, signed-overflow flag for the current result.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE; transitions: IDLE→CALC on start with b≠0; IDLE→FIX on start with b=0; CALC→FIX after exactly bits iterations; FIX→DONE; DONE→IDLE unconditionally.
REQ-014 SHALL latch a, b and sign into internal registers on the edge where start is sampled in IDLE; later changes on a, b and sign SHALL NOT affect the result.
REQ-015 SHALL, in signed mode, convert the latched operands to magnitudes before CALC and record the quotient sign (a_msb XOR b_msb) and the remainder sign (a_msb).
REQ-016 SHALL perform one restoring shift-subtract step per CALC cycle, MSB first, using a bits-wide iteration counter.
REQ-017 SHALL, in FIX, apply sign correction: quotient truncated toward zero, remainder carries the dividend's sign; the FIX edge SHALL load div, mod, div_err and ovf together.
REQ-018 SHALL assert ready for exactly one cycle in DONE: bits+2 cycles after the start-sample edge when b≠0, 2 cycles when b=0.
REQ-019 SHALL assert busy from the cycle after start is sampled until the end of DONE inclusive, and SHALL deassert it in IDLE.
REQ-020 SHALL ignore start while not in IDLE; no re-latch and no restart.
REQ-021 SHALL, for b=0, produce div = all ones, mod = latched a, div_err = 1 and ovf = 0.
REQ-022 SHALL, for signed a = most-negative and b = -1, produce div = most-negative (wrapped), mod = 0, ovf = 1 and div_err = 0.
REQ-023 SHALL hold div, mod, div_err and ovf stable from the FIX load until the next FIX load.
REQ-024 SHALL accept a new start in the cycle after DONE (back-to-back operation).

Reset
REQ-025 SHALL, while reset is low, force state IDLE and div = 0, mod = 0, ready = 0, busy = 0, div_err = 0 and ovf = 0, regardless of clk.
REQ-026 SHALL abort any division in progress when reset is asserted mid-operation, with no ready pulse for the aborted operation.

Structure
REQ-027 SHALL place the state encoding constants and the default width in a shared package/header used by the block and its bench.
REQ-028 SHALL isolate a single restoring step (shift, trial subtract, quotient bit) in a combinational sub-module named div_step.

Verification (bits=8 unless stated)
REQ-029 SHALL cover unsigned a=100, b=7 → div=14, mod=2, ready exactly 10 cycles after the start-sample edge, busy high throughout.
REQ-030 SHALL cover signed a=0xF9 (-7), b=2 → div=0xFD (-3), mod=0xFF (-1), ovf=0.
REQ-031 SHALL cover a=200, b=0 → ready after 2 cycles, div=0xFF, mod=0xC8, div_err=1.
REQ-032 SHALL cover signed a=0x80, b=0xFF → div=0x80, mod=0x00, ovf=1.
REQ-033 SHALL cover start pulsed mid-CALC with new operands, and a reset pulse mid-CALC → the first case still yields the original result; the reset case yields all outputs 0, no ready, and a fresh start succeeding.
REQ-034 SHALL cover bits=16 unsigned a=65535, b=1 → div=65535, mod=0, ready 18 cycles after the start-sample edge.
